// File: rtl/usb_pkg.sv
// usb_pkg: shared constants, state encoding and CRC16 helper for the USB
// full-speed receive path.
package usb_pkg;

  localparam int unsigned CNT_W           = 7;
  localparam int unsigned MAX_PAYLOAD_DEF = 64;

  // 4-bit PID codes (low nibble of the PID byte)
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [7:0]  SYNC_BYTE     = 8'b1000_0000;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PID,
    ST_TOKEN_B1,
    ST_TOKEN_B2,
    ST_TOKEN_EOP,
    ST_DATA_RX,
    ST_ERR_WAIT
  } rx_state_t;

  // One byte of CRC16, bits taken LSB first as they arrive on the wire
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_rx.sv
// crc16_rx: running CRC16 over received data bytes (poly 0x8005, init FFFF).
// Ports:
//   i_clk, i_n_rst   clock, async active-low reset
//   i_clear          sync reload to the init value (wins over i_en)
//   i_en, i_data     fold one byte into the CRC
//   o_crc_nxt_c      combinational value the register takes this cycle, so a
//                    byte and EOP in the same cycle can be checked together
module crc16_rx
  import usb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_n_rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc_nxt_c
);

  logic [15:0] r_crc;

  always_comb begin
    o_crc_nxt_c = r_crc;
    if (i_clear)   o_crc_nxt_c = CRC16_INIT;
    else if (i_en) o_crc_nxt_c = crc16_byte(r_crc, i_data);
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) r_crc <= CRC16_INIT;
    else          r_crc <= o_crc_nxt_c;
  end

endmodule

// File: rtl/rxpu.sv
// rxpu: USB full-speed receive packet unit. Parses SYNC/PID/token/data
// packets from the byte receiver, streams data payload (CRC16 stripped and
// checked) into the RX FIFO and requests DATA1/NAK replies from the TXPU.
// Ports:
//   i_clk, i_n_rst                 clock, async active-low reset
//   i_rcv_byte, i_byte_valid       received byte strobe
//   i_eop_detect                   end-of-packet strobe
//   i_is_txing                     TXPU busy: hold in IDLE, ignore inputs
//   i_fifo_full                    RX FIFO back-pressure
//   o_fifo_w_enable, o_fifo_w_data RX FIFO write port
//   o_fifo_clear                   flush FIFO after a bad data packet
//   o_send_data, o_send_nak        TXPU requests
//   o_data_done, o_rx_error        packet status pulses
// Build option: define RXPU_ADDR_FILTER_EN to drop tokens (and the data
// packet following an OUT) whose address differs from DEV_ADDR.
module rxpu
  import usb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'd1,
  parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic [7:0] i_rcv_byte,
  input  logic       i_byte_valid,
  input  logic       i_eop_detect,
  input  logic       i_is_txing,
  input  logic       i_fifo_full,
  output logic       o_fifo_w_enable,
  output logic [7:0] o_fifo_w_data,
  output logic       o_fifo_clear,
  output logic       o_send_data,
  output logic       o_send_nak,
  output logic       o_data_done,
  output logic       o_rx_error
);

`ifdef RXPU_ADDR_FILTER_EN
  localparam bit ADDR_FILTER = 1'b1;
`else
  localparam bit ADDR_FILTER = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD);

  rx_state_t        r_state;
  logic             r_tok_in;
  logic [6:0]       r_addr;
  logic             r_err_data;   // ERR_WAIT was entered from DATA_RX
  logic             r_drop;       // current data packet belongs to a foreign OUT
  logic [1:0]       r_held;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_d0;         // oldest held byte
  logic [7:0]       r_d1;         // newest held byte

  logic             w_byte;
  logic             w_pid_ok;
  logic [3:0]       w_pid;
  logic             w_addr_ok;
  logic             w_good;
  logic [15:0]      w_crc_nxt;

  // Register values after this cycle's byte (before any same-cycle EOP)
  rx_state_t        w_st;
  logic             w_tok_in;
  logic [6:0]       w_addr;
  logic             w_err_data;
  logic [1:0]       w_held;
  logic [CNT_W-1:0] w_cnt;
  logic [7:0]       w_d0;
  logic [7:0]       w_d1;
  logic             w_wr;
  logic [7:0]       w_wr_data;
  logic             w_crc_clr;
  logic             w_crc_en;

  assign w_byte    = i_byte_valid && !i_is_txing;
  assign w_pid     = i_rcv_byte[3:0];
  assign w_pid_ok  = (i_rcv_byte[7:4] == ~i_rcv_byte[3:0]);
  assign w_addr_ok = !ADDR_FILTER || (r_addr == DEV_ADDR);
  assign w_good    = (w_crc_nxt == CRC16_RESIDUE) && (w_held == 2'd2) && (w_cnt <= CNT_MAX);

  crc16_rx u_crc (
    .i_clk       (i_clk),
    .i_n_rst     (i_n_rst),
    .i_clear     (w_crc_clr),
    .i_en        (w_crc_en),
    .i_data      (i_rcv_byte),
    .o_crc_nxt_c (w_crc_nxt)
  );

  // Byte stage: effect of an incoming byte on the parser
  always_comb begin
    w_st       = r_state;
    w_tok_in   = r_tok_in;
    w_addr     = r_addr;
    w_err_data = r_err_data;
    w_held     = r_held;
    w_cnt      = r_cnt;
    w_d0       = r_d0;
    w_d1       = r_d1;
    w_wr       = 1'b0;
    w_wr_data  = r_d0;
    w_crc_clr  = 1'b0;
    w_crc_en   = 1'b0;
    if (w_byte) begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_rcv_byte == SYNC_BYTE) w_st = ST_WAIT_PID;
        end
        ST_WAIT_PID: begin
          w_st       = ST_ERR_WAIT;
          w_err_data = 1'b0;
          if (w_pid_ok) begin
            case (w_pid)
              PID_OUT, PID_IN: begin
                w_st     = ST_TOKEN_B1;
                w_tok_in = (w_pid == PID_IN);
              end
              PID_DATA0, PID_DATA1: begin
                w_st      = ST_DATA_RX;
                w_held    = 2'd0;
                w_cnt     = '0;
                w_d0      = 8'h00;
                w_d1      = 8'h00;
                w_crc_clr = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_TOKEN_B1: begin
          w_addr = i_rcv_byte[6:0];
          w_st   = ST_TOKEN_B2;
        end
        ST_TOKEN_B2: w_st = ST_TOKEN_EOP;
        ST_TOKEN_EOP: begin
          w_st       = ST_ERR_WAIT;
          w_err_data = 1'b0;
        end
        ST_DATA_RX: begin
          // Two-byte delay line keeps the trailing CRC out of the FIFO
          w_crc_en = 1'b1;
          w_d0     = r_d1;
          w_d1     = i_rcv_byte;
          if (r_held != 2'd2) begin
            w_held = r_held + 2'd1;
          end else if ((r_cnt == CNT_MAX) || i_fifo_full) begin
            w_st       = ST_ERR_WAIT;
            w_err_data = 1'b1;
          end else begin
            w_wr  = !r_drop;
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        ST_ERR_WAIT: ;
        default: w_st = ST_IDLE;
      endcase
    end
  end

  // State register, EOP handling and registered outputs
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state         <= ST_IDLE;
      r_tok_in        <= 1'b0;
      r_addr          <= 7'd0;
      r_err_data      <= 1'b0;
      r_drop          <= 1'b0;
      r_held          <= 2'd0;
      r_cnt           <= '0;
      r_d0            <= 8'h00;
      r_d1            <= 8'h00;
      o_fifo_w_enable <= 1'b0;
      o_fifo_w_data   <= 8'h00;
      o_fifo_clear    <= 1'b0;
      o_send_data     <= 1'b0;
      o_send_nak      <= 1'b0;
      o_data_done     <= 1'b0;
      o_rx_error      <= 1'b0;
    end else begin
      o_fifo_w_enable <= 1'b0;
      o_fifo_clear    <= 1'b0;
      o_send_data     <= 1'b0;
      o_send_nak      <= 1'b0;
      o_data_done     <= 1'b0;
      o_rx_error      <= 1'b0;
      if (i_is_txing) begin
        // Silent abort: no pulses, FIFO left alone
        r_state <= ST_IDLE;
      end else begin
        r_tok_in   <= w_tok_in;
        r_addr     <= w_addr;
        r_err_data <= w_err_data;
        r_held     <= w_held;
        r_cnt      <= w_cnt;
        r_d0       <= w_d0;
        r_d1       <= w_d1;
        o_fifo_w_enable <= w_wr;
        if (w_wr) o_fifo_w_data <= w_wr_data;
        if (!i_eop_detect) begin
          r_state <= w_st;
        end else begin
          r_state <= ST_IDLE;
          unique case (w_st)
            ST_IDLE: ;
            ST_TOKEN_EOP: begin
              o_send_data <= r_tok_in && w_addr_ok;
              r_drop      <= !w_addr_ok;
            end
            ST_DATA_RX: begin
              r_drop <= 1'b0;
              if (r_drop) begin
                o_rx_error <= !w_good;
              end else if (w_good) begin
                o_data_done <= 1'b1;
              end else begin
                o_fifo_clear <= 1'b1;
                o_send_nak   <= 1'b1;
                o_rx_error   <= 1'b1;
              end
            end
            ST_ERR_WAIT: begin
              o_rx_error <= 1'b1;
              if (w_err_data) begin
                r_drop       <= 1'b0;
                o_fifo_clear <= !r_drop;
                o_send_nak   <= !r_drop;
              end
            end
            default: o_rx_error <= 1'b1;  // truncated PID or token
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rxpu.sv
module tb_rxpu;

  logic       clk;
  logic       rst_n;
  logic [7:0] rcv_byte;
  logic       byte_valid;
  logic       eop_detect;
  logic       is_txing;
  logic       fifo_full;
  logic       fifo_w_enable;
  logic [7:0] fifo_w_data;
  logic       fifo_clear;
  logic       send_data;
  logic       send_nak;
  logic       data_done;
  logic       rx_error;

  rxpu dut (
    .i_clk           (clk),
    .i_n_rst         (rst_n),
    .i_rcv_byte      (rcv_byte),
    .i_byte_valid    (byte_valid),
    .i_eop_detect    (eop_detect),
    .i_is_txing      (is_txing),
    .i_fifo_full     (fifo_full),
    .o_fifo_w_enable (fifo_w_enable),
    .o_fifo_w_data   (fifo_w_data),
    .o_fifo_clear    (fifo_clear),
    .o_send_data     (send_data),
    .o_send_nak      (send_nak),
    .o_data_done     (data_done),
    .o_rx_error      (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [7:0]      pid;
    logic [3:0]      nb;
    logic [5:0][7:0] body;      // body[0] sent first
    logic            add_crc;
    logic [15:0]     crc_xor;   // corrupts the appended CRC
    logic            eop_same;  // EOP in the cycle of the last byte
    logic [3:0]      n_wr;      // expected writes = body[0..n_wr-1]
    logic [4:0]      flags;     // {send_data, send_nak, data_done, rx_error, fifo_clear}
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];

  logic [7:0] wq[$];
  int n_sd, n_nak, n_done, n_err, n_clr;
  int total, bad;

  // Output collector: outputs are registered pulses, sampled on negedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_w_enable) wq.push_back(fifo_w_data);
      n_sd   += int'(send_data);
      n_nak  += int'(send_nak);
      n_done += int'(data_done);
      n_err  += int'(rx_error);
      n_clr  += int'(fifo_clear);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input logic v, input logic e);
    @(negedge clk);
    rcv_byte   = b;
    byte_valid = v;
    eop_detect = e;
  endtask

  task automatic settle();
    repeat (3) put(8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    wq.delete();
    n_sd = 0; n_nak = 0; n_done = 0; n_err = 0; n_clr = 0;
  endtask

  task automatic send_q(input bq_t q, input logic eop_same);
    for (int i = 0; i < q.size(); i++)
      put(q[i], 1'b1, eop_same && (i == q.size() - 1));
    if (!eop_same) put(8'h00, 1'b0, 1'b1);
    settle();
  endtask

  // Reflected CRC16 (poly 0xA001), complemented, as appended on the wire
  function automatic logic [15:0] crc_model(input bq_t d);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[i]) begin
      c ^= {8'h00, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t data_pkt(input logic [7:0] pid, input bq_t pl);
    bq_t q;
    logic [15:0] c;
    c = crc_model(pl);
    q.push_back(8'h80);
    q.push_back(pid);
    foreach (pl[i]) q.push_back(pl[i]);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    return q;
  endfunction

  task automatic check_obs(input string name, input bq_t expw, input logic [4:0] f);
    chk({name, ".nwr"}, wq.size(), expw.size());
    for (int i = 0; i < expw.size() && i < wq.size(); i++)
      chk($sformatf("%s.wr%0d", name, i), int'(wq[i]), int'(expw[i]));
    chk({name, ".send_data"},  n_sd,   int'(f[4]));
    chk({name, ".send_nak"},   n_nak,  int'(f[3]));
    chk({name, ".data_done"},  n_done, int'(f[2]));
    chk({name, ".rx_error"},   n_err,  int'(f[1]));
    chk({name, ".fifo_clear"}, n_clr,  int'(f[0]));
    clear_obs();
  endtask

  function automatic vec_t mk(input logic [7:0] pid, input int nb, input logic [47:0] body,
                              input logic add_crc, input logic [15:0] cx, input logic es,
                              input int nw, input logic [4:0] f);
    vec_t v;
    v.pid = pid; v.nb = 4'(nb); v.body = body; v.add_crc = add_crc;
    v.crc_xor = cx; v.eop_same = es; v.n_wr = 4'(nw); v.flags = f;
    return v;
  endfunction

  initial begin
    bq_t q, body, expw;
    logic [15:0] c;
    total = 0; bad = 0;
    rst_n = 1'b0; rcv_byte = 8'h00; byte_valid = 1'b0; eop_detect = 1'b0;
    is_txing = 1'b0; fifo_full = 1'b0;
    clear_obs();

    tbl[0]  = mk(8'h69, 2, 48'h2A01,         1'b0, 16'h0,    1'b0, 0, 5'b10000); // IN
    tbl[1]  = mk(8'h69, 2, 48'h2A01,         1'b0, 16'h0,    1'b1, 0, 5'b10000); // IN, EOP with last
    tbl[2]  = mk(8'hE1, 2, 48'h2A01,         1'b0, 16'h0,    1'b0, 0, 5'b00000); // OUT
    tbl[3]  = mk(8'h4B, 4, 48'h04030201,     1'b1, 16'h0,    1'b0, 4, 5'b00100); // DATA1 good
    tbl[4]  = mk(8'h4B, 4, 48'h04030201,     1'b1, 16'h0001, 1'b0, 4, 5'b01011); // bad CRC
    tbl[5]  = mk(8'hC3, 0, 48'h0,            1'b1, 16'h0,    1'b0, 0, 5'b00100); // CRC only
    tbl[6]  = mk(8'hC3, 0, 48'h0,            1'b1, 16'h0,    1'b1, 0, 5'b00100);
    tbl[7]  = mk(8'h4B, 4, 48'h04030201,     1'b1, 16'h0,    1'b1, 4, 5'b00100);
    tbl[8]  = mk(8'h4C, 2, 48'h2211,         1'b0, 16'h0,    1'b0, 0, 5'b00010); // PID check fail
    tbl[9]  = mk(8'hD2, 0, 48'h0,            1'b0, 16'h0,    1'b0, 0, 5'b00010); // unsupported PID
    tbl[10] = mk(8'h4B, 1, 48'h55,           1'b0, 16'h0,    1'b0, 0, 5'b01011); // one byte only
    tbl[11] = mk(8'h69, 1, 48'h01,           1'b0, 16'h0,    1'b0, 0, 5'b00010); // short token
    tbl[12] = mk(8'h69, 3, 48'h332A01,       1'b0, 16'h0,    1'b0, 0, 5'b00010); // long token
    tbl[13] = mk(8'hC3, 6, 48'hA5A4A3A2A1A0, 1'b1, 16'h8000, 1'b0, 6, 5'b01011);
    tbl[14] = mk(8'hC3, 1, 48'h5A,           1'b1, 16'h0,    1'b0, 1, 5'b00100);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.outs", int'({fifo_w_enable, fifo_w_data, fifo_clear, send_data, send_nak, data_done, rx_error}), 0);
    rst_n = 1'b1;
    settle();
    chk("idle.outs", int'({fifo_w_enable, fifo_w_data, fifo_clear, send_data, send_nak, data_done, rx_error}), 0);
    clear_obs();

    // Table-driven packets
    for (int v = 0; v < NV; v++) begin
      q.delete(); body.delete(); expw.delete();
      q.push_back(8'h80);
      q.push_back(tbl[v].pid);
      for (int i = 0; i < int'(tbl[v].nb); i++) body.push_back(tbl[v].body[i]);
      foreach (body[i]) q.push_back(body[i]);
      if (tbl[v].add_crc) begin
        c = crc_model(body) ^ tbl[v].crc_xor;
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
      end
      for (int i = 0; i < int'(tbl[v].n_wr); i++) expw.push_back(tbl[v].body[i]);
      send_q(q, tbl[v].eop_same);
      check_obs($sformatf("vec%0d", v), expw, tbl[v].flags);
    end

    // Write latency and single-cycle strobe
    put(8'h80, 1'b1, 1'b0); put(8'h4B, 1'b1, 1'b0);
    put(8'hAA, 1'b1, 1'b0); put(8'hBB, 1'b1, 1'b0); put(8'hCC, 1'b1, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    chk("lat.wen", int'(fifo_w_enable), 1);
    chk("lat.wdata", int'(fifo_w_data), 32'hAA);
    put(8'h00, 1'b0, 1'b1);
    chk("lat.wen_off", int'(fifo_w_enable), 0);
    settle();
    clear_obs();

    // Garbage bytes in IDLE, then an IN token
    q = '{8'h00, 8'h55, 8'hFF, 8'h80, 8'h69, 8'h01, 8'h2A};
    send_q(q, 1'b0);
    expw.delete();
    check_obs("garbage", expw, 5'b10000);

    // SYNC then EOP
    q = '{8'h80};
    send_q(q, 1'b0);
    check_obs("sync_eop", expw, 5'b00010);

    // 64-byte payload is legal
    body.delete(); expw.delete();
    for (int i = 1; i <= 64; i++) begin body.push_back(8'(i)); expw.push_back(8'(i)); end
    send_q(data_pkt(8'h4B, body), 1'b0);
    check_obs("pl64", expw, 5'b00100);

    // 65-byte payload overflows: exactly 64 writes, then flush + NAK
    body.push_back(8'd65);
    send_q(data_pkt(8'h4B, body), 1'b0);
    check_obs("pl65", expw, 5'b01011);

    // FIFO full when the first write is due
    body = '{8'h01, 8'h02, 8'h03, 8'h04};
    expw.delete();
    fifo_full = 1'b1;
    send_q(data_pkt(8'h4B, body), 1'b0);
    fifo_full = 1'b0;
    check_obs("fifo_full", expw, 5'b01011);

    // TXPU busy mid-packet: silent abort
    q = data_pkt(8'h4B, body);
    for (int i = 0; i < q.size(); i++) begin
      put(q[i], 1'b1, 1'b0);
      if (i == 3) is_txing = 1'b1;
    end
    put(8'h00, 1'b0, 1'b1);
    settle();
    is_txing = 1'b0;
    settle();
    check_obs("txing", expw, 5'b00000);

    // Reset mid-packet returns to IDLE
    q = '{8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < q.size(); i++) put(q[i], 1'b1, 1'b0);
    settle();
    expw = '{8'h01, 8'h02};
    check_obs("rstmid.pre", expw, 5'b00000);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid.outs", int'({fifo_w_enable, fifo_clear, send_data, send_nak, data_done, rx_error}), 0);
    rst_n = 1'b1;
    put(8'h05, 1'b1, 1'b0); put(8'h06, 1'b1, 1'b0); put(8'h00, 1'b0, 1'b1);
    settle();
    expw.delete();
    check_obs("rstmid.post", expw, 5'b00000);

    // Foreign address: IN token, then OUT + DATA1
    q = '{8'h80, 8'h69, 8'h05, 8'h2A};
    send_q(q, 1'b0);
`ifdef RXPU_ADDR_FILTER_EN
    check_obs("addr5.in", expw, 5'b00000);
`else
    check_obs("addr5.in", expw, 5'b10000);
`endif
    q = '{8'h80, 8'hE1, 8'h05, 8'h2A};
    send_q(q, 1'b0);
    send_q(data_pkt(8'h4B, body), 1'b0);
`ifdef RXPU_ADDR_FILTER_EN
    check_obs("addr5.out", expw, 5'b00000);
`else
    expw = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_obs("addr5.out", expw, 5'b00100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
